// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: sequences one round of the number-guessing game.
// Fetches the secret from the puzzle BRAM, accepts guesses, strobes the
// feedback stage, tracks remaining attempts and keeps a saturating win score.
// Optional: define GUESS_HINT_EN to add the hint_high/hint_low outputs.
module guess_round_ctrl #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int BRAM_LAT    = 1,
  parameter int MAX_TRIES   = 3,
  parameter int SHOW_CYCLES = 50000000,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               guess_valid,
  input  logic [DATA_W-1:0]  player_guess,
  output logic               bram_en,
  output logic [ADDR_W-1:0]  bram_addr,
  input  logic [DATA_W-1:0]  bram_data,
  output logic [DATA_W-1:0]  guess_q,
  output logic [DATA_W-1:0]  secret_q,
  output logic               guess_submitted,
  output logic [3:0]         attempts_left,
  output logic               round_win,
  output logic               round_lose,
  output logic [SCORE_W-1:0] score,
  output logic               busy
`ifdef GUESS_HINT_EN
  ,
  output logic               hint_high,
  output logic               hint_low
`endif
);

  localparam int SHOW_W = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_GUESS,
    SHOW,
    WIN,
    LOSE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          fetch_cnt_q, fetch_cnt_d;
  logic [SHOW_W-1:0]   show_cnt_q, show_cnt_d;
  logic                match_q, match_d;
  logic                bram_en_q, bram_en_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   guess_d, secret_d;
  logic                guess_submitted_q, guess_submitted_d;
  logic [3:0]          attempts_left_q, attempts_left_d;
  logic                round_win_q, round_win_d;
  logic                round_lose_q, round_lose_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                busy_q, busy_d;
`ifdef GUESS_HINT_EN
  logic                hint_high_q, hint_high_d;
  logic                hint_low_q, hint_low_d;
`endif

  // Next-state and next-output computation for the round sequencer
  always_comb begin
    state_d           = state_q;
    fetch_cnt_d       = fetch_cnt_q;
    show_cnt_d        = show_cnt_q;
    match_d           = match_q;
    bram_en_d         = 1'b0;
    bram_addr_d       = bram_addr_q;
    guess_d           = guess_q;
    secret_d          = secret_q;
    guess_submitted_d = guess_submitted_q;
    attempts_left_d   = attempts_left_q;
    round_win_d       = 1'b0;
    round_lose_d      = 1'b0;
    score_d           = score_q;
`ifdef GUESS_HINT_EN
    hint_high_d       = hint_high_q;
    hint_low_d        = hint_low_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          bram_en_d   = 1'b1;
          fetch_cnt_d = '0;
        end
      end

      FETCH: begin
        // Data is valid BRAM_LAT cycles after the enable cycle
        if (fetch_cnt_q == 2'(BRAM_LAT)) begin
          secret_d        = bram_data;
          attempts_left_d = 4'(MAX_TRIES);
          state_d         = WAIT_GUESS;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 2'd1;
        end
      end

      WAIT_GUESS: begin
        if (guess_valid) begin
          guess_d           = player_guess;
          match_d           = (player_guess == secret_q);
          show_cnt_d        = '0;
          guess_submitted_d = 1'b1;
          state_d           = SHOW;
`ifdef GUESS_HINT_EN
          hint_high_d       = (player_guess > secret_q);
          hint_low_d        = (player_guess < secret_q);
`endif
        end
      end

      SHOW: begin
        if (show_cnt_q == SHOW_W'(SHOW_CYCLES - 1)) begin
          guess_submitted_d = 1'b0;
`ifdef GUESS_HINT_EN
          hint_high_d       = 1'b0;
          hint_low_d        = 1'b0;
`endif
          if (match_q) begin
            state_d     = WIN;
            round_win_d = 1'b1;
            score_d     = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            bram_addr_d = bram_addr_q + ADDR_W'(1);
          end else if (attempts_left_q > 4'd1) begin
            attempts_left_d = attempts_left_q - 4'd1;
            state_d         = WAIT_GUESS;
          end else begin
            attempts_left_d = '0;
            state_d         = LOSE;
            round_lose_d    = 1'b1;
            bram_addr_d     = bram_addr_q + ADDR_W'(1);
          end
        end else begin
          show_cnt_d = show_cnt_q + SHOW_W'(1);
        end
      end

      WIN, LOSE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      fetch_cnt_q       <= '0;
      show_cnt_q        <= '0;
      match_q           <= 1'b0;
      bram_en_q         <= 1'b0;
      bram_addr_q       <= '0;
      guess_q           <= '0;
      secret_q          <= '0;
      guess_submitted_q <= 1'b0;
      attempts_left_q   <= 4'(MAX_TRIES);
      round_win_q       <= 1'b0;
      round_lose_q      <= 1'b0;
      score_q           <= '0;
      busy_q            <= 1'b0;
`ifdef GUESS_HINT_EN
      hint_high_q       <= 1'b0;
      hint_low_q        <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      fetch_cnt_q       <= fetch_cnt_d;
      show_cnt_q        <= show_cnt_d;
      match_q           <= match_d;
      bram_en_q         <= bram_en_d;
      bram_addr_q       <= bram_addr_d;
      guess_q           <= guess_d;
      secret_q          <= secret_d;
      guess_submitted_q <= guess_submitted_d;
      attempts_left_q   <= attempts_left_d;
      round_win_q       <= round_win_d;
      round_lose_q      <= round_lose_d;
      score_q           <= score_d;
      busy_q            <= busy_d;
`ifdef GUESS_HINT_EN
      hint_high_q       <= hint_high_d;
      hint_low_q        <= hint_low_d;
`endif
    end
  end

  assign bram_en         = bram_en_q;
  assign bram_addr       = bram_addr_q;
  assign guess_submitted = guess_submitted_q;
  assign attempts_left   = attempts_left_q;
  assign round_win       = round_win_q;
  assign round_lose      = round_lose_q;
  assign score           = score_q;
  assign busy            = busy_q;
`ifdef GUESS_HINT_EN
  assign hint_high       = hint_high_q;
  assign hint_low        = hint_low_q;
`endif

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: behavioural round model compared every cycle,
// plus literal expectations for the key scenarios.
module tb_guess_round_ctrl;

  localparam int DATA_W      = 4;
  localparam int ADDR_W      = 2;
  localparam int BRAM_LAT    = 1;
  localparam int MAX_TRIES   = 3;
  localparam int SHOW_CYCLES = 4;
  localparam int SCORE_W     = 2;
  localparam int ADDR_MOD    = 1 << ADDR_W;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              guess_valid = 1'b0;
  logic [DATA_W-1:0] player_guess = '0;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic [DATA_W-1:0] guess_q;
  logic [DATA_W-1:0] secret_q;
  logic              guess_submitted;
  logic [3:0]        attempts_left;
  logic              round_win;
  logic              round_lose;
  logic [SCORE_W-1:0] score;
  logic              busy;
`ifdef GUESS_HINT_EN
  logic              hint_high;
  logic              hint_low;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  guess_round_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BRAM_LAT(BRAM_LAT),
    .MAX_TRIES(MAX_TRIES), .SHOW_CYCLES(SHOW_CYCLES), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid),
    .player_guess(player_guess), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_data(bram_data), .guess_q(guess_q), .secret_q(secret_q),
    .guess_submitted(guess_submitted), .attempts_left(attempts_left),
    .round_win(round_win), .round_lose(round_lose), .score(score), .busy(busy)
`ifdef GUESS_HINT_EN
    , .hint_high(hint_high), .hint_low(hint_low)
`endif
  );

  // Puzzle BRAM: fixed contents, data valid only BRAM_LAT cycles after enable
  logic [DATA_W-1:0] mem [ADDR_MOD] = '{4'd7, 4'd5, 4'd9, 4'd2};
  logic [DATA_W-1:0] pipe_d [BRAM_LAT] = '{default: '0};
  logic              pipe_v [BRAM_LAT] = '{default: 1'b0};

  always @(posedge clk) begin
    pipe_v[0] <= bram_en;
    pipe_d[0] <= mem[bram_addr];
    for (int i = 1; i < BRAM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign bram_data = pipe_v[BRAM_LAT-1] ? pipe_d[BRAM_LAT-1] : ~pipe_d[BRAM_LAT-1];

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_FETCH, PH_GUESS, PH_SHOW, PH_DONE} phase_t;

  phase_t            m_phase = PH_IDLE;
  int                m_left = 0;
  int                m_addr = 0;
  int                m_score = 0;
  int                m_att = MAX_TRIES;
  logic [DATA_W-1:0] m_guess = '0;
  logic [DATA_W-1:0] m_secret = '0;
  logic              m_bram_en = 1'b0;
  logic              m_sub = 1'b0;
  logic              m_win = 1'b0;
  logic              m_lose = 1'b0;
  logic              m_busy = 1'b0;
  logic              m_hh = 1'b0;
  logic              m_hl = 1'b0;

  task automatic model_reset();
    m_phase = PH_IDLE; m_left = 0; m_addr = 0; m_score = 0; m_att = MAX_TRIES;
    m_guess = '0; m_secret = '0; m_bram_en = 1'b0; m_sub = 1'b0;
    m_win = 1'b0; m_lose = 1'b0; m_busy = 1'b0; m_hh = 1'b0; m_hl = 1'b0;
  endtask

  task automatic model_step();
    m_bram_en = 1'b0;
    m_win     = 1'b0;
    m_lose    = 1'b0;
    case (m_phase)
      PH_IDLE: if (start) begin
        m_phase = PH_FETCH; m_bram_en = 1'b1; m_left = BRAM_LAT + 1; m_busy = 1'b1;
      end
      PH_FETCH: begin
        m_left--;
        if (m_left == 0) begin
          m_secret = mem[m_addr];
          m_att    = MAX_TRIES;
          m_phase  = PH_GUESS;
        end
      end
      PH_GUESS: if (guess_valid) begin
        m_guess = player_guess; m_sub = 1'b1; m_left = SHOW_CYCLES;
        m_hh = (player_guess > m_secret); m_hl = (player_guess < m_secret);
        m_phase = PH_SHOW;
      end
      PH_SHOW: begin
        m_left--;
        if (m_left == 0) begin
          m_sub = 1'b0; m_hh = 1'b0; m_hl = 1'b0;
          if (m_guess == m_secret) begin
            m_win   = 1'b1;
            m_score = (m_score >= SCORE_MAX) ? SCORE_MAX : m_score + 1;
            m_addr  = (m_addr + 1) % ADDR_MOD;
            m_phase = PH_DONE;
          end else if (m_att > 1) begin
            m_att--;
            m_phase = PH_GUESS;
          end else begin
            m_att   = 0;
            m_lose  = 1'b1;
            m_addr  = (m_addr + 1) % ADDR_MOD;
            m_phase = PH_DONE;
          end
        end
      end
      PH_DONE: begin
        m_busy  = 1'b0;
        m_phase = PH_IDLE;
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare and event monitors ----------------
  int   n_windows = 0;
  int   n_win = 0;
  int   n_lose = 0;
  int   cur_len = 0;
  int   last_len = 0;
  logic prev_gs = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      chk("bram_en",         32'(bram_en),         32'(m_bram_en));
      chk("bram_addr",       32'(bram_addr),       32'(m_addr));
      chk("guess_q",         32'(guess_q),         32'(m_guess));
      chk("secret_q",        32'(secret_q),        32'(m_secret));
      chk("guess_submitted", 32'(guess_submitted), 32'(m_sub));
      chk("attempts_left",   32'(attempts_left),   32'(m_att));
      chk("round_win",       32'(round_win),       32'(m_win));
      chk("round_lose",      32'(round_lose),      32'(m_lose));
      chk("score",           32'(score),           32'(m_score));
      chk("busy",            32'(busy),            32'(m_busy));
`ifdef GUESS_HINT_EN
      chk("hint_high",       32'(hint_high),       32'(m_hh));
      chk("hint_low",        32'(hint_low),        32'(m_hl));
`endif
      if (guess_submitted && !prev_gs) n_windows++;
      if (guess_submitted) cur_len++;
      else if (prev_gs) begin last_len = cur_len; cur_len = 0; end
      prev_gs = guess_submitted;
      if (round_win === 1'b1) n_win++;
      if (round_lose === 1'b1) n_lose++;
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_guess(input logic [DATA_W-1:0] g);
    player_guess = g;
    guess_valid  = 1'b1;
    @(negedge clk);
    guess_valid  = 1'b0;
  endtask

  task automatic wait_phase(input phase_t p, input string what);
    int n = 0;
    while (m_phase != p && n < 50) begin @(negedge clk); n++; end
    if (m_phase != p) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got phase %0d expected %0d", what, m_phase, p);
    end
  endtask

  task automatic wait_idle(input string what);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got busy %0b expected 0", what, busy);
    end
  endtask

  int w0;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_attempts", 32'(attempts_left), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round 1: addr 0, secret 7, guessed first time
    pulse_start();
    wait_phase(PH_GUESS, "r1_fetch");
    chk("r1_secret", 32'(secret_q), 32'd7);
    chk("r1_attempts", 32'(attempts_left), 32'd3);
    do_guess(4'd7);
    wait_idle("r1_end");
    chk("r1_window_len", 32'(last_len), 32'd4);
    chk("r1_wins", 32'(n_win), 32'd1);
    chk("r1_score", 32'(score), 32'd1);
    chk("r1_addr", 32'(bram_addr), 32'd1);
    chk("r1_busy", 32'(busy), 32'd0);

    // Round 2: addr 1, secret 5, three misses
    w0 = n_windows;
    pulse_start();
    wait_phase(PH_GUESS, "r2_fetch");
    chk("r2_att0", 32'(attempts_left), 32'd3);
    do_guess(4'd1);
    wait_phase(PH_GUESS, "r2_g1");
    chk("r2_att1", 32'(attempts_left), 32'd2);
    do_guess(4'd2);
    wait_phase(PH_GUESS, "r2_g2");
    chk("r2_att2", 32'(attempts_left), 32'd1);
    do_guess(4'd3);
    wait_idle("r2_end");
    chk("r2_att3", 32'(attempts_left), 32'd0);
    chk("r2_windows", 32'(n_windows - w0), 32'd3);
    chk("r2_loses", 32'(n_lose), 32'd1);
    chk("r2_score", 32'(score), 32'd1);
    chk("r2_addr", 32'(bram_addr), 32'd2);

    // Round 3: addr 2, secret 9, ignored inputs and hints
    w0 = n_windows;
    do_guess(4'd8);
    @(negedge clk);
    chk("r3_idle_busy", 32'(busy), 32'd0);
    chk("r3_idle_guess", 32'(guess_q), 32'd3);
    player_guess = 4'd8;
    guess_valid  = 1'b1;
    pulse_start();
    guess_valid  = 1'b0;
    do_guess(4'd8);
    wait_phase(PH_GUESS, "r3_fetch");
    chk("r3_guess_kept", 32'(guess_q), 32'd3);
    pulse_start();
    do_guess(4'd3);
`ifdef GUESS_HINT_EN
    chk("r3_hint_low", 32'(hint_low), 32'd1);
    chk("r3_hint_high", 32'(hint_high), 32'd0);
`endif
    do_guess(4'd9);
    wait_phase(PH_GUESS, "r3_g1");
    chk("r3_guess_after_drop", 32'(guess_q), 32'd3);
    chk("r3_att", 32'(attempts_left), 32'd2);
    do_guess(4'd12);
`ifdef GUESS_HINT_EN
    chk("r3_hint_high2", 32'(hint_high), 32'd1);
    chk("r3_hint_low2", 32'(hint_low), 32'd0);
`endif
    wait_phase(PH_GUESS, "r3_g2");
    do_guess(4'd9);
`ifdef GUESS_HINT_EN
    chk("r3_hint_match", 32'({hint_high, hint_low}), 32'd0);
`endif
    wait_idle("r3_end");
    chk("r3_windows", 32'(n_windows - w0), 32'd3);
    chk("r3_score", 32'(score), 32'd2);
    chk("r3_addr", 32'(bram_addr), 32'd3);

    // Round 4: addr 3, secret 2 -> address wraps
    pulse_start();
    wait_phase(PH_GUESS, "r4_fetch");
    do_guess(4'd2);
    wait_idle("r4_end");
    chk("r4_score", 32'(score), 32'd3);
    chk("r4_addr_wrap", 32'(bram_addr), 32'd0);

    // Round 5: addr 0 again, win -> score saturates
    pulse_start();
    wait_phase(PH_GUESS, "r5_fetch");
    do_guess(4'd7);
    wait_idle("r5_end");
    chk("r5_score_sat", 32'(score), 32'd3);
    chk("r5_addr", 32'(bram_addr), 32'd1);
    chk("r5_wins", 32'(n_win), 32'd4);

    // Round 6: reset asserted between edges during SHOW
    pulse_start();
    wait_phase(PH_GUESS, "r6_fetch");
    do_guess(4'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("r6_rst_gs", 32'(guess_submitted), 32'd0);
    chk("r6_rst_busy", 32'(busy), 32'd0);
    chk("r6_rst_addr", 32'(bram_addr), 32'd0);
    chk("r6_rst_score", 32'(score), 32'd0);
    chk("r6_rst_att", 32'(attempts_left), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Round 7: normal operation after reset
    pulse_start();
    wait_phase(PH_GUESS, "r7_fetch");
    chk("r7_secret", 32'(secret_q), 32'd7);
    do_guess(4'd7);
    wait_idle("r7_end");
    chk("r7_score", 32'(score), 32'd1);
    chk("r7_addr", 32'(bram_addr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Sequences one round of the number-guessing game:
  - fetches the secret value from the puzzle BRAM;
  - accepts player guesses;
  - drives the feedback block's compare strobe and operands;
  - counts remaining attempts and keeps score.
- Sits between the debounced button/switch inputs, the puzzle BRAM read port and the LED feedback stage.

Parameters:
- DATA_W, 4, width of guess and secret values
- ADDR_W, 4, puzzle BRAM address width; one secret per address
- BRAM_LAT, 1, BRAM read latency in cycles (1..3) from bram_en to valid bram_data
- MAX_TRIES, 3, guesses allowed per round (1..15)
- SHOW_CYCLES, 50000000, cycles guess_submitted is held per guess (>=2)
- SCORE_W, 8, width of the win counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a round
- guess_valid  in  1  one-cycle pulse: player_guess is a submitted guess
- player_guess  in  DATA_W  guess from switches
- bram_en  out  1  BRAM read enable, one-cycle pulse
- bram_addr  out  ADDR_W  current puzzle address
- bram_data  in  DATA_W  BRAM read data, valid BRAM_LAT cycles after bram_en
- guess_q  out  DATA_W  latched guess, to feedback player_guess
- secret_q  out  DATA_W  latched secret, to feedback bram_data
- guess_submitted  out  1  compare strobe to feedback, held through SHOW
- attempts_left  out  4  remaining guesses in the current round
- round_win  out  1  one-cycle pulse: round won
- round_lose  out  1  one-cycle pulse: round lost
- score  out  SCORE_W  rounds won since reset
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; bram_addr=0; score=0; attempts_left=MAX_TRIES.
  - guess_q, secret_q, bram_en, guess_submitted, round_win, round_lose, busy all 0.
  - Reset mid-round abandons the round; guess_submitted drops without waiting for a clock edge.
- States: IDLE, FETCH, WAIT_GUESS, SHOW, WIN, LOSE. All outputs are registered.
- IDLE:
  - start=1 -> FETCH; bram_en=1 for exactly one cycle at the current bram_addr.
  - guess_valid is ignored.
- FETCH:
  - Counts BRAM_LAT cycles after the bram_en cycle, then latches bram_data into secret_q.
  - Sets attempts_left=MAX_TRIES and goes to WAIT_GUESS.
  - start and guess_valid are ignored.
- WAIT_GUESS:
  - guess_valid=1 -> latch player_guess into guess_q, start the SHOW counter, go to SHOW.
  - guess_submitted rises on the cycle after the accepting edge.
- SHOW:
  - guess_submitted is held high for exactly SHOW_CYCLES cycles, so feedback LEDs light one cycle later.
  - Match is evaluated from guess_q==secret_q at entry and registered internally.
  - On counter expiry guess_submitted drops, then:
    - match -> WIN;
    - mismatch with attempts_left>1 -> attempts_left-1, go to WAIT_GUESS;
    - mismatch with attempts_left==1 -> attempts_left=0, go to LOSE.
  - guess_valid during SHOW is dropped, not queued.
- WIN (1 cycle):
  - round_win=1.
  - score+1, saturating at 2^SCORE_W-1.
  - bram_addr+1, wrapping from 2^ADDR_W-1 to 0.
  - Go to IDLE.
- LOSE (1 cycle): round_lose=1; bram_addr+1 with the same wrap; score unchanged; go to IDLE.
- Simultaneous events:
  - start and guess_valid together in IDLE -> start wins, guess dropped.
  - start while busy is ignored; no restart.
- guess_q and secret_q hold their values after the round until the next latch.

Optional Feature:
- Macro GUESS_HINT_EN.
- Defined:
  - Adds outputs hint_high and hint_low (1 bit each), registered on guess acceptance, unsigned compare.
  - hint_high=1 if guess_q>secret_q; hint_low=1 if guess_q<secret_q; both 0 on a match.
  - Both are valid only while guess_submitted=1 and are forced to 0 otherwise and on reset.
- Undefined: the ports and logic do not exist; all other behaviour is identical.

Test Plan:
- SHOW_CYCLES=4, BRAM addr0=7; start, then guess 7 -> bram_en pulse with addr 0; secret_q=7 after BRAM_LAT; guess_submitted high 4 cycles; round_win pulse; score=1; bram_addr=1; busy=0.
- MAX_TRIES=3, secret 5; guesses 1,2,3 -> attempts_left 3->2->1->0; three guess_submitted windows; round_lose pulse once; score stays 0; bram_addr advances.
- guess_valid pulses during IDLE, FETCH and SHOW, plus start during WAIT_GUESS -> no state change, guess_q unchanged, no extra guess_submitted window.
- ADDR_W=2: four consecutive rounds -> bram_addr 0,1,2,3 then 0. SCORE_W=2: four wins -> score saturates at 3.
- Assert rst mid-SHOW, asynchronously between edges -> guess_submitted=0 and busy=0 immediately; bram_addr=0, score=0, attempts_left=3.
- GUESS_HINT_EN defined, secret 9: guess 3 -> hint_low=1, hint_high=0 during SHOW; guess 12 -> hint_high=1; guess 9 -> both 0 with round_win.
